// File: rtl/nn_pkg.sv
// Shared sizes and state encoding for the neuron weight path.
package nn_pkg;

  localparam int unsigned W_WIDTH    = 8;
  localparam int unsigned NUM_HIDDEN = 8;
  localparam int unsigned NUM_INPUTS = 4;
  localparam int unsigned NUM_HW     = NUM_HIDDEN * NUM_INPUTS;
  localparam int unsigned NUM_W      = NUM_HW + NUM_HIDDEN;
  // Weight bytes plus the trailing checksum byte.
  localparam int unsigned FRAME_LEN  = NUM_W + 1;
  localparam int unsigned CNT_W      = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCheck
  } state_e;

endpackage

// File: rtl/weight_loader_if.sv
// Byte-serial weight load channel between the pin driver and weight_loader.
interface weight_loader_if;
  import nn_pkg::*;

  logic               start;
  logic               strobe;
  logic [W_WIDTH-1:0] data;
  logic               ready;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, strobe, data,
    input  ready, busy, done, err
  );

  modport slave (
    input  start, strobe, data,
    output ready, busy, done, err
  );

endinterface

// File: rtl/strobe_sync.sv
// Two-flop synchronizer with rising-edge detect for an asynchronous pin.
module strobe_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/weight_loader.sv
// Loads a checksummed weight frame into a shadow file and commits it atomically
// to the active weight buses only when the trailing XOR checksum matches.
module weight_loader
  import nn_pkg::*;
(
  input  logic                               clk_i,
  input  logic                               rst_i,
  weight_loader_if.slave                     bus,
  output logic [NUM_HW*W_WIDTH-1:0]          hw_o,
  output logic [NUM_HIDDEN*W_WIDTH-1:0]      ow_o,
  output logic                               weights_valid_o
);

  logic accept;

  strobe_sync u_strobe_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .pin_i  (bus.strobe),
    .rise_o (accept)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W_WIDTH-1:0] xor_q, xor_d;
  logic               match_q, match_d;
  logic               shadow_we, commit, err_set, err_clr;
  logic               err_q, done_q, valid_q;
  logic [W_WIDTH-1:0] shadow_q [NUM_W];
  logic [W_WIDTH-1:0] active_q [NUM_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    xor_d     = xor_q;
    match_d   = match_q;
    shadow_we = 1'b0;
    commit    = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoad;
          cnt_d   = '0;
          xor_d   = '0;
          err_clr = 1'b1;
        end
      end
      StLoad: begin
        // start beats a coincident strobe: restart and drop the byte.
        if (bus.start) begin
          cnt_d = '0;
          xor_d = '0;
        end else if (accept) begin
          if (cnt_q == CNT_W'(NUM_W)) begin
            match_d = (bus.data == xor_q);
            state_d = StCheck;
          end else begin
            shadow_we = 1'b1;
            xor_d     = xor_q ^ bus.data;
            cnt_d     = cnt_q + 1'b1;
          end
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (match_q) commit = 1'b1;
        else         err_set = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      xor_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      match_q <= match_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_W; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (shadow_we) shadow_q[cnt_q] <= bus.data;
      if (commit) begin
        active_q <= shadow_q;
        valid_q  <= 1'b1;
      end
      done_q <= commit;
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  always_comb begin
    hw_o = '0;
    ow_o = '0;
    for (int k = 0; k < NUM_HW; k++) hw_o[k*W_WIDTH +: W_WIDTH] = active_q[k];
    for (int k = 0; k < NUM_HIDDEN; k++) ow_o[k*W_WIDTH +: W_WIDTH] = active_q[NUM_HW+k];
  end

  assign bus.ready       = (state_q == StLoad);
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign weights_valid_o = valid_q;

endmodule
